// File: rtl/dino_pkg.sv
// Shared dino runner types: FSM states, renderer pose codes and
// default motion constants.
package dino_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RUN  = 3'd1;
  localparam state_t S_JUMP = 3'd2;
  localparam state_t S_DUCK = 3'd3;
  localparam state_t S_DEAD = 3'd4;

  typedef logic [1:0] pose_t;

  localparam pose_t P_RUN  = 2'd0;
  localparam pose_t P_JUMP = 2'd1;
  localparam pose_t P_DUCK = 2'd2;
  localparam pose_t P_DEAD = 2'd3;

  localparam logic [7:0] DEF_GROUND_Y = 8'd168;
  localparam logic [6:0] DEF_JUMP_V0  = 7'd12;
  localparam logic [6:0] DEF_GRAVITY  = 7'd1;
  localparam logic [3:0] DEF_ANIM_DIV = 4'd6;

  // IDLE shares the RUN sprite.
  function automatic pose_t state_pose(state_t s);
    pose_t p;
    case (s)
      S_JUMP:  p = P_JUMP;
      S_DUCK:  p = P_DUCK;
      S_DEAD:  p = P_DEAD;
      default: p = P_RUN;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear,
// saturating at 999.
module bcd_counter3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] q
);

  logic [11:0] r_q;
  logic        w_c0;
  logic        w_c1;
  logic        w_sat;

  assign w_sat = (r_q == 12'h999);
  assign w_c0  = (r_q[3:0] == 4'd9);
  assign w_c1  = w_c0 && (r_q[7:4] == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 12'h000;
    end else if (clr) begin
      r_q <= 12'h000;
    end else if (inc && !w_sat) begin
      r_q[3:0] <= w_c0 ? 4'd0 : r_q[3:0] + 4'd1;
      if (w_c0)
        r_q[7:4] <= w_c1 ? 4'd0 : r_q[7:4] + 4'd1;
      if (w_c1)
        r_q[11:8] <= r_q[11:8] + 4'd1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Frame-rate dino state engine: FSM, jump physics, run-leg phase
// and distance score, all refreshed at the frame boundary.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter logic [7:0] GROUND_Y = DEF_GROUND_Y,
  parameter logic [6:0] JUMP_V0  = DEF_JUMP_V0,
  parameter logic [6:0] GRAVITY  = DEF_GRAVITY,
  parameter logic [3:0] ANIM_DIV = DEF_ANIM_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump_req,
  input  logic        duck_hold,
  input  logic        hit,
  input  logic        restart,
  output logic [7:0]  dino_y,
  output logic [1:0]  pose,
  output logic [1:0]  leg,
  output logic        airborne,
  output logic [11:0] score_bcd,
  output logic        upd
);

  state_t      r_state;
  state_t      w_state_n;
  logic [7:0]  r_y;
  logic [7:0]  w_y_n;
  logic [6:0]  r_vel;
  logic [6:0]  w_vel_n;
  logic [1:0]  r_leg;
  logic [1:0]  w_leg_n;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_n;
  logic        r_pend;
  logic        r_upd;
  logic        w_upd_n;
  logic        w_sc_inc;
  logic        w_sc_clr;

  logic        w_live;
  logic        w_anim;
  logic        w_pend;
  logic        w_restart;
  logic        w_hit;
  logic        w_leg_step;

  logic signed [8:0] w_ynext;
  logic signed [8:0] w_ground;
  logic        w_vle0;
  logic [6:0]  w_dv;
  logic [6:0]  w_vdec;
  logic        w_ceil;
  logic        w_land;
  logic [7:0]  w_y_top;
  logic [6:0]  w_v_top;

  assign w_live = (r_state == S_RUN) ||
                  (r_state == S_JUMP) ||
                  (r_state == S_DUCK);
  assign w_anim = (r_state == S_RUN) ||
                  (r_state == S_DUCK);

  // A request in the tick cycle itself counts for that tick.
  assign w_pend    = r_pend | jump_req;
  assign w_restart = (r_state == S_DEAD) && restart;
  assign w_hit     = w_live && hit;

  assign w_leg_step = (r_cnt == ANIM_DIV - 4'd1);

  assign w_ynext  = $signed({1'b0, r_y}) -
                    $signed({{2{r_vel[6]}}, r_vel});
  assign w_ground = $signed({1'b0, GROUND_Y});

  // Fast fall once the dino is at or past the apex.
  assign w_vle0 = r_vel[6] || (r_vel == 7'd0);
  assign w_dv   = (duck_hold && w_vle0) ?
                  {GRAVITY[5:0], 1'b0} : GRAVITY;
  assign w_vdec = r_vel - w_dv;

  assign w_ceil = w_ynext[8];
  assign w_land = r_vel[6] && !w_ceil &&
                  (w_ynext >= w_ground);

  assign w_y_top = GROUND_Y - {1'b0, JUMP_V0};
  assign w_v_top = JUMP_V0 - GRAVITY;

  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_vel_n   = r_vel;
    w_leg_n   = r_leg;
    w_cnt_n   = r_cnt;
    w_upd_n   = 1'b0;
    w_sc_inc  = 1'b0;
    w_sc_clr  = 1'b0;
    if (w_restart) begin
      w_state_n = S_IDLE;
      w_y_n     = GROUND_Y;
      w_vel_n   = 7'd0;
      w_leg_n   = 2'd0;
      w_cnt_n   = 4'd0;
      w_sc_clr  = 1'b1;
      w_upd_n   = 1'b1;
    end else if (w_hit) begin
      w_state_n = S_DEAD;
      w_vel_n   = 7'd0;
      w_upd_n   = 1'b1;
    end else if (frame_tick) begin
      w_upd_n  = 1'b1;
      w_sc_inc = w_live;
      if (w_anim) begin
        w_cnt_n = w_leg_step ? 4'd0 : r_cnt + 4'd1;
        if (w_leg_step)
          w_leg_n = (r_leg == 2'd2) ? 2'd0 : r_leg + 2'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pend)
            w_state_n = S_RUN;
        end
        S_RUN, S_DUCK: begin
          if (w_pend) begin
            w_state_n = S_JUMP;
            w_y_n     = w_y_top;
            w_vel_n   = w_v_top;
          end else begin
            w_state_n = duck_hold ? S_DUCK : S_RUN;
          end
        end
        S_JUMP: begin
          unique case (1'b1)
            w_ceil: begin
              w_y_n   = 8'd0;
              w_vel_n = 7'd0;
            end
            w_land: begin
              w_y_n     = GROUND_Y;
              w_vel_n   = 7'd0;
              w_state_n = duck_hold ? S_DUCK : S_RUN;
            end
            default: begin
              w_y_n   = w_ynext[7:0];
              w_vel_n = w_vdec;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_y     <= GROUND_Y;
      r_vel   <= 7'd0;
      r_leg   <= 2'd0;
      r_cnt   <= 4'd0;
      r_upd   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_y     <= w_y_n;
      r_vel   <= w_vel_n;
      r_leg   <= w_leg_n;
      r_cnt   <= w_cnt_n;
      r_upd   <= w_upd_n;
      r_pend  <= frame_tick ? 1'b0 : w_pend;
    end
  end

  bcd_counter3 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (w_sc_clr),
    .inc   (w_sc_inc),
    .q     (score_bcd)
  );

  assign dino_y   = r_y;
  assign pose     = state_pose(r_state);
  assign leg      = r_leg;
  assign airborne = (r_state == S_JUMP);
  assign upd      = r_upd;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl: directed scenarios plus
// random play against a frame-level game model.
module tb_dino_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        jump_req = 1'b0;
  logic        duck_hold = 1'b0;
  logic        hit = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  dino_y;
  logic [1:0]  pose;
  logic [1:0]  leg;
  logic        airborne;
  logic [11:0] score_bcd;
  logic        upd;

  dino_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .jump_req   (jump_req),
    .duck_hold  (duck_hold),
    .hit        (hit),
    .restart    (restart),
    .dino_y     (dino_y),
    .pose       (pose),
    .leg        (leg),
    .airborne   (airborne),
    .score_bcd  (score_bcd),
    .upd        (upd)
  );

  always #10 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int stamp;
    int y;
    int pose;
    int leg;
    int air;
    int sc;
  } exp_t;

  exp_t q[$];
  exp_t last;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_JUMP = 2;
  localparam int M_DUCK = 3;
  localparam int M_DEAD = 4;

  int m_mode;
  int m_y;
  int m_vel;
  int m_score;
  int m_runs;
  bit m_pend;

  function automatic int bcd(int s);
    return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  function automatic exp_t snap(int st);
    exp_t e;
    e.stamp = st;
    e.y     = m_y;
    e.pose  = (m_mode == M_JUMP) ? 1 :
              (m_mode == M_DUCK) ? 2 :
              (m_mode == M_DEAD) ? 3 : 0;
    e.leg   = (m_runs / 6) % 3;
    e.air   = (m_mode == M_JUMP) ? 1 : 0;
    e.sc    = bcd(m_score);
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_y     = 168;
    m_vel   = 0;
    m_score = 0;
    m_runs  = 0;
    m_pend  = 1'b0;
    last    = snap(0);
    q.delete();
  endtask

  task automatic model_step(bit t, bit j, bit d, bit h, bit r);
    bit pe;
    bit live;
    bit u;
    int ny;
    int nv;
    pe   = m_pend | j;
    live = (m_mode == M_RUN) || (m_mode == M_JUMP) ||
           (m_mode == M_DUCK);
    u    = 1'b0;
    if (m_mode == M_DEAD && r) begin
      m_mode  = M_IDLE;
      m_y     = 168;
      m_vel   = 0;
      m_score = 0;
      m_runs  = 0;
      u       = 1'b1;
    end else if (live && h) begin
      m_mode = M_DEAD;
      m_vel  = 0;
      u      = 1'b1;
    end else if (t) begin
      u = 1'b1;
      if (live && m_score < 999) m_score++;
      if (m_mode == M_RUN || m_mode == M_DUCK) m_runs++;
      case (m_mode)
        M_IDLE: if (pe) m_mode = M_RUN;
        M_RUN, M_DUCK: begin
          if (pe) begin
            m_mode = M_JUMP;
            m_y    = 168 - 12;
            m_vel  = 12 - 1;
          end else begin
            m_mode = d ? M_DUCK : M_RUN;
          end
        end
        M_JUMP: begin
          ny = m_y - m_vel;
          nv = m_vel - ((d && m_vel <= 0) ? 2 : 1);
          if (ny < 0) begin
            m_y   = 0;
            m_vel = 0;
          end else if (m_vel < 0 && ny >= 168) begin
            m_y    = 168;
            m_vel  = 0;
            m_mode = d ? M_DUCK : M_RUN;
          end else begin
            m_y   = ny;
            m_vel = nv;
          end
        end
        default: ;
      endcase
    end
    m_pend = t ? 1'b0 : pe;
    if (u) q.push_back(snap(edges + 1));
  endtask

  task automatic cyc(bit t, bit j, bit d, bit h, bit r);
    @(negedge clk);
    frame_tick = t;
    jump_req   = j;
    duck_hold  = d;
    hit        = h;
    restart    = r;
    model_step(t, j, d, h, r);
  endtask

  task automatic ticks(int n, bit d);
    repeat (n) begin
      cyc(1, 0, d, 0, 0);
      cyc(0, 0, d, 0, 0);
    end
  endtask

  // Monitor: pops one expectation per upd strobe, otherwise
  // requires the outputs to hold their last refreshed values.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (upd) begin
          n_chk++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra_upd at edge %0d", edges);
          end else begin
            e = q.pop_front();
            if (e.stamp != edges || dino_y != e.y ||
                pose != e.pose || leg != e.leg ||
                airborne != e.air || score_bcd != e.sc) begin
              n_err++;
              $display({"FAIL sb_update: got edge=%0d y=%0d ",
                        "pose=%0d leg=%0d air=%0d sc=%h, want ",
                        "edge=%0d y=%0d pose=%0d leg=%0d air=%0d ",
                        "sc=%h"},
                       edges, dino_y, pose, leg, airborne,
                       score_bcd, e.stamp, e.y, e.pose, e.leg,
                       e.air, e.sc[11:0]);
            end
            last = e;
          end
        end else begin
          n_chk++;
          if (dino_y != last.y || pose != last.pose ||
              leg != last.leg || airborne != last.air ||
              score_bcd != last.sc) begin
            n_err++;
            $display({"FAIL sb_hold: got y=%0d pose=%0d leg=%0d ",
                      "air=%0d sc=%h, want y=%0d pose=%0d ",
                      "leg=%0d air=%0d sc=%h"},
                     dino_y, pose, leg, airborne, score_bcd,
                     last.y, last.pose, last.leg, last.air,
                     last.sc[11:0]);
          end
        end
      end
    end
  end

  initial begin
    int  n;
    bit  pt;
    bit  t;
    bit  j;
    bit  d;
    bit  h;
    bit  r;

    model_reset();
    #25;
    chk("rst_y", dino_y, 168);
    chk("rst_pose", pose, 0);
    chk("rst_leg", leg, 0);
    chk("rst_air", airborne, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_upd", upd, 0);
    @(negedge clk);
    reset = 1'b0;

    // Start: jump request held pending until the tick.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(1, 0);
    chk("start_pose", pose, 0);
    chk("start_score", score_bcd, 12'h000);
    ticks(6, 0);
    chk("run6_leg", leg, 1);
    chk("run6_score", score_bcd, 12'h006);
    ticks(12, 0);
    chk("run18_leg", leg, 0);
    chk("run18_score", score_bcd, 12'h018);

    // Full jump: request in the tick cycle itself.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("jump_y0", dino_y, 156);
    chk("jump_air", airborne, 1);
    chk("jump_pose", pose, 1);
    ticks(11, 0);
    chk("peak_y", dino_y, 90);
    ticks(1, 0);
    chk("peak_hold_y", dino_y, 90);
    ticks(12, 0);
    chk("land_y", dino_y, 168);
    chk("land_pose", pose, 0);
    chk("land_air", airborne, 0);
    chk("land_score", score_bcd, 12'h043);

    // Fast fall from the apex with duck held.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(11, 0);
    chk("ff_peak_y", dino_y, 90);
    n = 0;
    while (airborne && n < 30) begin
      ticks(1, 1);
      n++;
    end
    chk("ff_ticks", n, 10);
    chk("ff_y", dino_y, 168);
    chk("ff_pose", pose, 2);
    ticks(1, 1);
    chk("duck_stay", pose, 2);
    ticks(1, 0);
    chk("duck_exit", pose, 0);

    // Collision mid-air freezes everything.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(3, 0);
    chk("hit_pre_y", dino_y, 126);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hit_pose", pose, 3);
    chk("hit_y", dino_y, 126);
    ticks(3, 0);
    chk("dead_y", dino_y, 126);
    chk("dead_pose", pose, 3);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("restart_pose", pose, 0);
    chk("restart_y", dino_y, 168);
    chk("restart_score", score_bcd, 12'h000);
    chk("restart_leg", leg, 0);

    // Score carry and saturation.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(99, 0);
    chk("score_099", score_bcd, 12'h099);
    ticks(1, 0);
    chk("score_100", score_bcd, 12'h100);
    ticks(899, 0);
    chk("score_999", score_bcd, 12'h999);
    ticks(5, 0);
    chk("score_sat", score_bcd, 12'h999);

    // hit with tick, then restart with hit while DEAD.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(5, 0);
    chk("pre_ht_score", score_bcd, 12'h005);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ht_pose", pose, 3);
    chk("ht_score", score_bcd, 12'h005);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rh_pose", pose, 0);
    chk("rh_score", score_bcd, 12'h000);

    // Async reset mid-jump with a jump request pending.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(2, 0);
    cyc(1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_upd", upd, 1);
    frame_tick = 1'b0;
    jump_req   = 1'b1;
    @(posedge clk);
    #3;
    jump_req = 1'b0;
    reset    = 1'b1;
    model_reset();
    #1;
    chk("arst_y", dino_y, 168);
    chk("arst_pose", pose, 0);
    chk("arst_upd", upd, 0);
    chk("arst_air", airborne, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ticks(3, 0);
    chk("nopend_pose", pose, 0);
    chk("nopend_score", score_bcd, 12'h000);

    // Random play.
    pt = 1'b0;
    d  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      t = !pt && ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) d = ~d;
      h = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 24) == 0);
      cyc(t, j, d, h, r);
      pt = t;
    end
    cyc(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
